// File: rtl/main_memory_responder_if.sv
// -----------------------------------------------------------------------------
// main_memory_responder_if
//   Backing-store bus between a cache controller (master) and the
//   main-memory responder (slave).
//
//   Signals
//     RAMreadEnable   master->slave  read request, held until dataReady seen
//     RAMwriteEnable  master->slave  single-cycle write strobe
//     addr            master->slave  word address
//     dataIn          master->slave  write data, valid with RAMwriteEnable
//     dataOut         slave->master  registered read data
//     dataReady       slave->master  one-cycle read-completion pulse
//     busy            slave->master  read in progress
//     protocolErr     slave->master  sticky protocol-violation flag
// -----------------------------------------------------------------------------
interface main_memory_responder_if #(
  parameter int ramWidth = 8,
  parameter int addrSize = 8
) ();

  logic                RAMreadEnable;
  logic                RAMwriteEnable;
  logic [addrSize-1:0] addr;
  logic [ramWidth-1:0] dataIn;
  logic [ramWidth-1:0] dataOut;
  logic                dataReady;
  logic                busy;
  logic                protocolErr;

  modport master (
    output RAMreadEnable,
    output RAMwriteEnable,
    output addr,
    output dataIn,
    input  dataOut,
    input  dataReady,
    input  busy,
    input  protocolErr
  );

  modport slave (
    input  RAMreadEnable,
    input  RAMwriteEnable,
    input  addr,
    input  dataIn,
    output dataOut,
    output dataReady,
    output busy,
    output protocolErr
  );

endinterface

// File: rtl/main_memory_responder.sv
// -----------------------------------------------------------------------------
// main_memory_responder
//   RAM-side responder for the cache controller's backing store. Models a slow
//   DRAM-like array: writes complete in the cycle they are strobed, reads
//   complete after a fixed number of clock edges with a one-cycle dataReady
//   pulse.
//
//   Parameters
//     ramWidth     data word width in bits
//     addrSize     address width; array depth is 2**addrSize words
//     readLatency  edges from read capture to dataReady rise, 1..255
//
//   Ports
//     clk    system clock, all state updates on the rising edge
//     rst_n  asynchronous active-low reset (array contents are kept)
//     bus    slave side of main_memory_responder_if
//
//   Read timing (readLatency = L)
//     E0        request captured in IDLE, counter loaded with L-1
//     E1..EL-1  counter counts down in WAIT
//     EL        counter is zero: dataOut loaded, dataReady set, go DONE
//     EL+1      dataReady cleared, back to IDLE
//   busy is therefore high for L+1 cycles per read.
//
//   Protocol errors (sticky until reset)
//     - both enables high in IDLE: the write wins, the read is retried
//       next cycle if the initiator still holds it
//     - a write while a read is in flight: the write is dropped
// -----------------------------------------------------------------------------
module main_memory_responder #(
  parameter int ramWidth    = 8,
  parameter int addrSize    = 8,
  parameter int readLatency = 3
) (
  input  logic clk,
  input  logic rst_n,
  main_memory_responder_if.slave bus
);

  localparam int DEPTH = 2 ** addrSize;

  // One-hot state encoding.
  localparam logic [2:0] S_IDLE = 3'b001;
  localparam logic [2:0] S_WAIT = 3'b010;
  localparam logic [2:0] S_DONE = 3'b100;

  // Value loaded into the countdown on capture. The WAIT state spends one
  // edge per count plus the edge that sees zero, giving exactly readLatency
  // edges from capture to dataReady.
  localparam logic [7:0] LAT_LOAD = 8'(readLatency - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [2:0]          r_state;
  logic [7:0]          r_cnt;
  logic [addrSize-1:0] r_rd_addr;
  logic [ramWidth-1:0] r_data_out;
  logic                r_data_ready;
  logic                r_proto_err;

  logic [ramWidth-1:0] r_mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic w_idle;
  logic w_busy;
  logic w_write_accept;
  logic w_read_start;
  logic w_proto_err;

  assign w_idle = r_state[0];
  assign w_busy = r_state[1] | r_state[2];

  // Writes land only in IDLE; in WAIT/DONE they are discarded.
  assign w_write_accept = bus.RAMwriteEnable & w_idle;

  // A write in the same cycle takes priority over a read request.
  assign w_read_start = bus.RAMreadEnable & ~bus.RAMwriteEnable & w_idle;

  // Either a write colliding with a read request in IDLE, or any write
  // while a read is outstanding.
  assign w_proto_err = bus.RAMwriteEnable & (bus.RAMreadEnable | w_busy);

  // ---------------------------------------------------------------------------
  // Storage array
  // ---------------------------------------------------------------------------
  // NOTE: the array has no reset branch; clearing it would turn the RAM into
  // a huge flop bank, and the contents must survive rst_n anyway.
  always_ff @(posedge clk) begin
    if (w_write_accept) begin
      r_mem[bus.addr] <= bus.dataIn;
    end
  end

  // ---------------------------------------------------------------------------
  // Read sequencer
  // ---------------------------------------------------------------------------
  // NOTE: every register below is assigned with <= so all of them see the
  // pre-edge values of each other, exactly like the flops they become.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_rd_addr    <= '0;
      r_data_out   <= '0;
      r_data_ready <= 1'b0;
      r_proto_err  <= 1'b0;
    end else begin
      // dataReady is a single-cycle pulse; only the WAIT->DONE edge sets it.
      r_data_ready <= 1'b0;

      if (w_proto_err) begin
        r_proto_err <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_read_start) begin
            r_rd_addr <= bus.addr;
            r_cnt     <= LAT_LOAD;
            r_state   <= S_WAIT;
          end
        end

        S_WAIT: begin
          // The address is frozen in r_rd_addr; bus.addr may wander freely
          // and a dropped RAMreadEnable does not cancel the access.
          if (r_cnt != 8'd0) begin
            r_cnt <= r_cnt - 8'd1;
          end else begin
            r_data_out   <= r_mem[r_rd_addr];
            r_data_ready <= 1'b1;
            r_state      <= S_DONE;
          end
        end

        S_DONE: begin
          // A request still held here is not captured; it is picked up on
          // the next edge once back in IDLE.
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.dataOut     = r_data_out;
  assign bus.dataReady   = r_data_ready;
  assign bus.busy        = w_busy;
  assign bus.protocolErr = r_proto_err;

  // ---------------------------------------------------------------------------
  // Structural invariants
  // ---------------------------------------------------------------------------
  a_state_onehot : assert property (
    @(posedge clk) disable iff (!rst_n) $onehot(r_state)
  );

  // The pulse register and the DONE state move in lockstep.
  a_ready_in_done : assert property (
    @(posedge clk) disable iff (!rst_n) r_data_ready == r_state[2]
  );

endmodule

// File: tb/tb_main_memory_responder.sv
// -----------------------------------------------------------------------------
// tb_main_memory_responder
//   Three responders sharing clk/rst_n, built with readLatency 3, 1 and 255.
//   Each has its own bus interface and its own stimulus signals. Read
//   stimulus pushes {expected data, expected dataReady cycle} into a per-DUT
//   queue; a negedge monitor pops and compares on every dataReady pulse.
//   cyc counts rising edges, so at the falling edge after edge k, cyc == k.
// -----------------------------------------------------------------------------
module tb_main_memory_responder;

  localparam int NDUT = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Stimulus, one lane per DUT.
  logic [NDUT-1:0]      re;
  logic [NDUT-1:0]      we;
  logic [NDUT-1:0][7:0] addr;
  logic [NDUT-1:0][7:0] din;

  // Observed outputs.
  logic [NDUT-1:0]      rdy;
  logic [NDUT-1:0]      busy;
  logic [NDUT-1:0]      perr;
  logic [NDUT-1:0][7:0] dout;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 3 : ((g == 1) ? 1 : 255);

    main_memory_responder_if #(.ramWidth(8), .addrSize(8)) bus ();

    main_memory_responder #(
      .ramWidth   (8),
      .addrSize   (8),
      .readLatency(LAT)
    ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
    );

    assign bus.RAMreadEnable  = re[g];
    assign bus.RAMwriteEnable = we[g];
    assign bus.addr           = addr[g];
    assign bus.dataIn         = din[g];

    assign rdy[g]  = bus.dataReady;
    assign busy[g] = bus.busy;
    assign perr[g] = bus.protocolErr;
    assign dout[g] = bus.dataOut;
  end

  function automatic int lat_of(int d);
    case (d)
      0:       return 3;
      1:       return 1;
      default: return 255;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_total  = 0;
  int n_passed = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    n_total++;
    if (act === req) n_passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  typedef struct {
    logic [7:0] data;
    int         at;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  function automatic void push_exp(int d, logic [7:0] v, int at);
    exp_t e;
    e.data = v;
    e.at   = at;
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  function automatic int q_size(int d);
    case (d)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t pop_exp(int d);
    case (d)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  // Monitor: every dataReady pulse must match the oldest expectation, both in
  // data and in the exact cycle it appears. A pulse held for two cycles or a
  // spurious pulse finds an empty queue.
  always @(negedge clk) begin : monitor
    exp_t e;
    for (int d = 0; d < NDUT; d++) begin
      if (rdy[d] === 1'b1) begin
        check($sformatf("pulse_expected_dut%0d", d), 32'(q_size(d) != 0), 32'd1);
        if (q_size(d) != 0) begin
          e = pop_exp(d);
          check($sformatf("read_data_dut%0d", d), 32'(dout[d]), 32'(e.data));
          check($sformatf("ready_cycle_dut%0d", d), 32'(cyc), 32'(e.at));
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic do_write(int d, logic [7:0] a, logic [7:0] v);
    @(posedge clk); #1;
    we[d]   = 1'b1;
    addr[d] = a;
    din[d]  = v;
    @(posedge clk); #1;
    we[d] = 1'b0;
  endtask

  // Waits (bounded) for dataReady on lane d, counting busy cycles seen on the
  // way. Optionally drops RAMreadEnable on the falling edge where the pulse
  // is observed, which is before the DONE->IDLE edge.
  task automatic wait_ready(int d, bit drop, output int bcnt);
    bit seen;
    bcnt = 0;
    seen = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (busy[d]) bcnt++;
      if (rdy[d]) begin
        seen = 1'b1;
        if (drop) re[d] = 1'b0;
        break;
      end
    end
    check($sformatf("ready_seen_dut%0d", d), 32'(seen), 32'd1);
    if (!seen) re[d] = 1'b0;
  endtask

  // Plain read: capture on the next edge, expect data after readLatency edges,
  // busy for readLatency+1 cycles, a one-cycle pulse, and dataOut held.
  task automatic do_read(int d, logic [7:0] a, logic [7:0] v);
    int bc;
    @(posedge clk); #1;
    re[d]   = 1'b1;
    addr[d] = a;
    push_exp(d, v, cyc + 1 + lat_of(d));
    wait_ready(d, 1'b1, bc);
    check($sformatf("busy_cycles_dut%0d", d), 32'(bc), 32'(lat_of(d) + 1));
    @(negedge clk);
    check($sformatf("pulse_width_dut%0d", d), 32'(rdy[d]), 32'd0);
    check($sformatf("busy_after_dut%0d", d), 32'(busy[d]), 32'd0);
    check($sformatf("dout_hold_dut%0d", d), 32'(dout[d]), 32'(v));
  endtask

  // Two reads with RAMreadEnable held high throughout: 0x00 then 0xFF.
  // The second capture happens two edges after the first pulse (DONE->IDLE,
  // then IDLE capture), so it completes readLatency+2 cycles later.
  task automatic read_pair(int d, logic [7:0] v0, logic [7:0] vff);
    int bc;
    int t0;
    @(posedge clk); #1;
    re[d]   = 1'b1;
    addr[d] = 8'h00;
    t0 = cyc + 1 + lat_of(d);
    push_exp(d, v0, t0);
    push_exp(d, vff, t0 + lat_of(d) + 2);
    wait_ready(d, 1'b0, bc);
    addr[d] = 8'hFF;
    wait_ready(d, 1'b1, bc);
    check($sformatf("pair_busy_cycles_dut%0d", d), 32'(bc), 32'(lat_of(d) + 1));
    @(negedge clk);
    check($sformatf("pair_pulse_width_dut%0d", d), 32'(rdy[d]), 32'd0);
    check($sformatf("pair_dout_dut%0d", d), 32'(dout[d]), 32'(vff));
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int bc;
    re   = '0;
    we   = '0;
    addr = '0;
    din  = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("reset_ready_dut%0d", d), 32'(rdy[d]), 32'd0);
      check($sformatf("reset_busy_dut%0d", d), 32'(busy[d]), 32'd0);
      check($sformatf("reset_perr_dut%0d", d), 32'(perr[d]), 32'd0);
      check($sformatf("reset_dout_dut%0d", d), 32'(dout[d]), 32'd0);
    end
    rst_n = 1'b1;

    // Write 0x5A@0x10 and read it back with latency 3.
    do_write(0, 8'h10, 8'h5A);
    do_read(0, 8'h10, 8'h5A);
    check("perr_clean_t1", 32'(perr[0]), 32'd0);

    // Write during WAIT is dropped and flags a protocol error.
    do_write(0, 8'h20, 8'h11);
    @(posedge clk); #1;
    re[0]   = 1'b1;
    addr[0] = 8'h20;
    push_exp(0, 8'h11, cyc + 1 + 3);
    @(posedge clk); #1;
    we[0]  = 1'b1;
    din[0] = 8'hC3;
    @(posedge clk); #1;
    we[0] = 1'b0;
    check("perr_write_in_wait", 32'(perr[0]), 32'd1);
    wait_ready(0, 1'b1, bc);
    do_read(0, 8'h20, 8'h11);
    check("perr_sticky", 32'(perr[0]), 32'd1);

    // Both enables in IDLE: write wins, read captured one edge later.
    check("perr_clean_t4", 32'(perr[1]), 32'd0);
    @(posedge clk); #1;
    re[1]   = 1'b1;
    we[1]   = 1'b1;
    addr[1] = 8'h30;
    din[1]  = 8'h77;
    push_exp(1, 8'h77, cyc + 2 + 1);
    @(posedge clk); #1;
    we[1] = 1'b0;
    check("perr_both_enables", 32'(perr[1]), 32'd1);
    check("busy_not_yet_t4", 32'(busy[1]), 32'd0);
    wait_ready(1, 1'b1, bc);
    do_read(1, 8'h30, 8'h77);

    // Reset one cycle into WAIT: no pulse, outputs cleared, array kept.
    @(posedge clk); #1;
    re[0]   = 1'b1;
    addr[0] = 8'h10;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("busy_before_reset", 32'(busy[0]), 32'd1);
    rst_n = 1'b0;
    re[0] = 1'b0;
    #1;
    check("abort_ready", 32'(rdy[0]), 32'd0);
    check("abort_busy", 32'(busy[0]), 32'd0);
    check("abort_dout", 32'(dout[0]), 32'd0);
    check("abort_perr", 32'(perr[0]), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    check("idle_after_abort", 32'(busy[0]), 32'd0);
    do_read(0, 8'h10, 8'h5A);

    // Latency extremes with back-to-back reads at both address ends.
    do_write(1, 8'h00, 8'hA5);
    do_write(1, 8'hFF, 8'h3C);
    read_pair(1, 8'hA5, 8'h3C);
    do_write(2, 8'h00, 8'h96);
    do_write(2, 8'hFF, 8'h69);
    read_pair(2, 8'h96, 8'h69);
    check("perr_clean_t6", 32'(perr[2]), 32'd0);

    // A write never disturbs dataOut.
    do_write(1, 8'hFF, 8'h01);
    @(negedge clk);
    check("dout_after_write", 32'(dout[1]), 32'h3C);

    repeat (4) @(posedge clk);
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("no_lost_pulse_dut%0d", d), 32'(q_size(d)), 32'd0);
    end

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected under 20000", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
